in_buff_rr_arbiter: RTL and testbench
=====================================

Name: in_buff_rr_arbiter

Overview:
- Round-robin burst arbiter that drains NUM_CH per-channel input FIFOs (one per transducer channel group) into the single shared beamformer ingest port.
- Grants one channel at a time for a burst of up to burst_len beats.
- Channels reporting almost_full take urgent priority, so no channel overflows.
- Output is a registered valid/ready stage tagged with the source channel index.

Parameters:
- DATA_WIDTH, 16, sample width per beat
- NUM_CH, 4, number of requesting channel FIFOs (2..16)
- CH_W, $clog2(NUM_CH), width of channel index
- BL_W, 8, width of burst length configuration

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  arbitration enable; sampled only when no grant is active
- burst_len  in  BL_W  beats per grant; sampled at grant; 0 treated as 1
- ch_valid  in  NUM_CH  per-channel FIFO out_valid
- ch_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_almost_full  in  NUM_CH  per-channel FIFO almost_full
- ch_ready  out  NUM_CH  per-channel ready_out to the FIFOs; one-hot or zero
- out_valid  out  1  ingest-port data valid
- out_data  out  DATA_WIDTH  ingest-port data
- out_ch  out  CH_W  source channel of out_data
- out_last  out  1  marks the burst_len-th beat of a burst
- out_ready  in  1  downstream ready
- busy  out  1  high while in state BURST

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, out_valid=0, out_data=0, out_ch=0, out_last=0, ch_ready=0, busy=0.
- Output stage: stage_free = !out_valid || out_ready.
- Channel accept: ch_ready[i] = (state==BURST) && (grant==i) && stage_free, combinational. A beat transfers when ch_valid[grant] && ch_ready[grant].
- On a beat transfer: out_data/out_ch register the beat next cycle, out_valid<=1. Latency is 1 cycle from FIFO pop to out_valid.
- If out_ready && out_valid with no new beat: out_valid<=0 next cycle.
- out_valid/out_data hold stable while out_valid && !out_ready.
- FSM states: IDLE, BURST.
- IDLE -> BURST when enable && |ch_valid:
  - Urgent set U = ch_valid & ch_almost_full. If U is nonzero, pick the first set bit of U searching from rr_ptr upward with wrap. Otherwise pick the first set bit of ch_valid from rr_ptr with wrap.
  - Latch grant, latch burst length (0 -> 1), beat_cnt=0.
- BURST: beat_cnt increments on each transfer. out_last registers (beat_cnt == len-1) alongside the data.
- BURST -> IDLE on either:
  - the transfer where beat_cnt == len-1, or
  - a cycle with stage_free && !ch_valid[grant] (channel ran dry; burst ends early, and no out_last is emitted for that burst).
- On every BURST -> IDLE: rr_ptr <= grant+1, wrapping to 0 after NUM_CH-1.
- IDLE is always occupied for at least one cycle between grants. Back-to-back grants therefore have a 1-cycle bubble on ch_ready.
- enable deasserted during BURST: the burst completes normally; no new grant is issued.
- Simultaneous events: a final-beat transfer and a channel's almost_full rising in the same cycle is evaluated in the following IDLE cycle. The pointer update precedes the next search.
- Single requester: the same channel is re-granted after the 1-cycle IDLE gap, even though rr_ptr has advanced past it.
- Arithmetic: beat_cnt is BL_W bits and the comparison is unsigned. rr_ptr wrap is explicit, with no reliance on power-of-2 NUM_CH.
- Reset mid-burst: all state clears immediately. Any beat already popped but not yet accepted downstream is dropped; the system-level reset clears the FIFOs as well.

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE, ST_BURST) and the default BL_W.
- One sub-module, rr_pick: combinational rotate-priority encoder (req vector, start pointer -> index, found). Instantiated twice: urgent set and plain set.

Test Plan:
- Reset, then NUM_CH=4, burst_len=4, all ch_valid=1, out_ready=1 -> grants 0,1,2,3,0 in order. Each burst is 4 beats with out_last on beat 4, and ch_ready drops for exactly 1 cycle between bursts.
- Channel 2 valid only, burst_len=0 -> single-beat bursts: out_last=1 every beat, out_ch=2, one beat every 2 cycles.
- rr_ptr=1, ch_valid=4'b1111, ch_almost_full=4'b1000 -> channel 3 granted before 1 and 2; the next grant is 0.
- out_ready held low for 5 cycles mid-burst -> out_data stable, ch_ready=0, no FIFO pop. On release, the burst resumes with correct beat_cnt and no lost or duplicated beat.
- ch_valid[1] drops after 2 of 8 beats -> burst ends, no out_last, and channel 2 is granted next.
- Assert reset asynchronously mid-burst (between clock edges) -> out_valid=0, ch_ready=0, busy=0 immediately. After release the first grant goes to the lowest valid channel from index 0.

Source files
------------

// File: rtl/in_buff_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin input-buffer arbiter.
package in_buff_rr_arbiter_pkg;

    localparam int unsigned BL_W_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/in_buff_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req at or after start, wrapping.
module rr_pick
    import in_buff_rr_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // One extra bit holds start+i; explicit wrap keeps non-power-of-2 N correct.
            pos = {1'b0, start} + (W+1)'(i);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (!found && req[pos[W-1:0]]) begin
                found = 1'b1;
                idx   = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/in_buff_rr_arbiter.sv
// Burst round-robin arbiter draining per-channel FIFOs into one registered ingest port.
module in_buff_rr_arbiter
    import in_buff_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = $clog2(NUM_CH),
    parameter int unsigned BL_W       = BL_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [BL_W-1:0]              burst_len,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_almost_full,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy
);

    state_t                state;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       grant;
    logic [BL_W-1:0]       beat_cnt;
    logic [BL_W-1:0]       len;

    logic                  stage_free;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  last_beat;
    logic [CH_W-1:0]       next_ptr;
    logic [BL_W-1:0]       start_len;

    logic [NUM_CH-1:0]     urgent;
    logic [CH_W-1:0]       urg_idx;
    logic                  urg_found;
    logic [CH_W-1:0]       plain_idx;
    logic                  plain_found;
    logic [CH_W-1:0]       pick_idx;

    assign urgent = ch_valid & ch_almost_full;

    rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick_urgent (
        .req   (urgent),
        .start (rr_ptr),
        .idx   (urg_idx),
        .found (urg_found)
    );

    rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick_plain (
        .req   (ch_valid),
        .start (rr_ptr),
        .idx   (plain_idx),
        .found (plain_found)
    );

    assign pick_idx   = urg_found ? urg_idx : plain_idx;
    assign stage_free = !out_valid || out_ready;
    assign sel_valid  = ch_valid[grant];
    assign xfer       = (state == ST_BURST) && stage_free && sel_valid;
    assign last_beat  = (beat_cnt == len - 1'b1);
    assign next_ptr   = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    assign start_len  = (burst_len == '0) ? BL_W'(1) : burst_len;
    assign busy       = (state == ST_BURST);

    always_comb begin
        sel_data = '0;
        ch_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_data    = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                ch_ready[i] = (state == ST_BURST) && stage_free;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            len       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= grant;
                out_last  <= last_beat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && (|ch_valid)) begin
                        grant    <= pick_idx;
                        len      <= start_len;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state  <= ST_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (stage_free && !sel_valid) begin
                        // Channel ran dry with the stage able to take data: close the burst early.
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_buff_rr_arbiter.sv
// Self-checking bench: cycle-level reference model plus directed scenarios with literal pins.
module tb_in_buff_rr_arbiter;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int BIG = 100000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [7:0]    burst_len = 8'd0;
    logic [3:0]    ch_valid;
    logic [63:0]   ch_data;
    logic [3:0]    ch_almost_full = 4'b0;
    logic [3:0]    ch_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic [1:0]    out_ch;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;

    in_buff_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .CH_W       (2),
        .BL_W       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .burst_len      (burst_len),
        .ch_valid       (ch_valid),
        .ch_data        (ch_data),
        .ch_almost_full (ch_almost_full),
        .ch_ready       (ch_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ch         (out_ch),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // FIFO stand-ins: a channel is valid while its pop count is below its limit.
    logic [31:0] pops  [NC] = '{default: 32'd0};
    logic [31:0] limit [NC] = '{default: 32'd0};

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            ch_valid[i] = pops[i] < limit[i];
            ch_data[i*DW +: DW] = {4'(i), pops[i][11:0]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (ch_valid[i] && ch_ready[i]) pops[i] <= pops[i] + 32'd1;
        end
    end

    // Reference model.
    typedef struct packed {
        logic        busy;
        logic        ov;
        logic        last;
        logic [15:0] data;
        logic [1:0]  och;
        logic [1:0]  grant;
        logic [1:0]  ptr;
        logic [8:0]  rem;
    } mstate_t;

    mstate_t m = '0;
    mstate_t m_next;
    int      gq[$];

    function automatic logic [1:0] pick(input logic [3:0] v, input logic [3:0] af, input int ptr);
        logic [3:0] cand;
        logic [1:0] res;
        logic       hit;
        cand = ((v & af) != 4'b0) ? (v & af) : v;
        res  = 2'd0;
        hit  = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (!hit && cand[(ptr + k) % NC]) begin
                hit = 1'b1;
                res = 2'((ptr + k) % NC);
            end
        end
        return res;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic en, input logic [7:0] bl,
                                     input logic [3:0] v, input logic [3:0] af,
                                     input logic [63:0] d, input logic ordy);
        mstate_t n;
        logic    room;
        int      g;
        n    = s;
        room = !s.ov || ordy;
        g    = int'(s.grant);
        if (s.busy) begin
            if (room && v[g]) begin
                n.ov   = 1'b1;
                n.data = d[g*DW +: DW];
                n.och  = s.grant;
                n.last = (s.rem == 9'd1);
                n.rem  = s.rem - 9'd1;
                if (s.rem == 9'd1) begin
                    n.busy = 1'b0;
                    n.ptr  = 2'((g + 1) % NC);
                end
            end else begin
                if (ordy) n.ov = 1'b0;
                if (room) begin
                    n.busy = 1'b0;
                    n.ptr  = 2'((g + 1) % NC);
                end
            end
        end else begin
            if (ordy) n.ov = 1'b0;
            if (en && v != 4'b0) begin
                n.busy  = 1'b1;
                n.grant = pick(v, af, int'(s.ptr));
                n.rem   = (bl == 8'd0) ? 9'd1 : {1'b0, bl};
            end
        end
        return n;
    endfunction

    always_comb m_next = step(m, enable, burst_len, ch_valid, ch_almost_full, ch_data, out_ready);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '0;
        end else begin
            m <= m_next;
            if (m_next.busy && !m.busy) gq.push_back(int'(m_next.grant));
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-cycle output comparison against the model.
    initial begin
        logic [3:0] exp_rdy;
        forever begin
            @(negedge clk);
            exp_rdy = (m.busy && (!m.ov || out_ready)) ? 4'(4'd1 << m.grant) : 4'b0;
            chk("ch_ready",  32'(ch_ready),  32'(exp_rdy));
            chk("busy",      32'(busy),      32'(m.busy));
            chk("out_valid", 32'(out_valid), 32'(m.ov));
            chk("out_data",  32'(out_data),  32'(m.data));
            chk("out_ch",    32'(out_ch),    32'(m.och));
            chk("out_last",  32'(out_last),  32'(m.last));
        end
    end

    // Downstream acceptance counters (observed from the DUT, compared to literals).
    int n_beats = 0;
    int n_lasts = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                n_beats++;
                if (out_last) n_lasts++;
            end
        end
    end

    task automatic wait_grants(input int target, input int budget);
        int k;
        k = 0;
        while (gq.size() < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (gq.size() < target) begin
            n_cmp++; n_err++;
            $display("FAIL wait_grant: got %0d grants expected %0d", gq.size(), target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((m.busy || m.ov) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (m.busy || m.ov) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: got busy %0d expected 0", m.busy);
        end
    endtask

    task automatic set_limits(input int n0, input int n1, input int n2, input int n3);
        limit[0] = pops[0] + 32'(n0);
        limit[1] = pops[1] + 32'(n1);
        limit[2] = pops[2] + 32'(n2);
        limit[3] = pops[3] + 32'(n3);
    endtask

    // Run one single-beat grant on channel 0 so the pointer lands on 1.
    task automatic ptr_to_one();
        set_limits(1, 0, 0, 0);
        burst_len = 8'd1;
        enable = 1'b1;
        wait_grants(gq.size() + 1, 50);
        enable = 1'b0;
        wait_idle(50);
    endtask

    initial begin
        int b, beats0, lasts0;
        logic [31:0] p0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ch_ready",  32'(ch_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full round robin, 4-beat bursts.
        b = gq.size(); beats0 = n_beats; lasts0 = n_lasts;
        set_limits(BIG, BIG, BIG, BIG);
        burst_len = 8'd4;
        enable = 1'b1;
        wait_grants(b + 5, 200);
        enable = 1'b0;
        wait_idle(100);
        chk("t1_g0", 32'(gq[b]),   32'd0);
        chk("t1_g1", 32'(gq[b+1]), 32'd1);
        chk("t1_g2", 32'(gq[b+2]), 32'd2);
        chk("t1_g3", 32'(gq[b+3]), 32'd3);
        chk("t1_g4", 32'(gq[b+4]), 32'd0);
        chk("t1_beats", 32'(n_beats - beats0), 32'd20);
        chk("t1_lasts", 32'(n_lasts - lasts0), 32'd5);

        // Single requester, burst_len 0 -> one beat every two cycles.
        beats0 = n_beats; lasts0 = n_lasts; p0 = pops[2];
        set_limits(0, 0, BIG, 0);
        burst_len = 8'd0;
        enable = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_idle(50);
        chk("t2_pops",  pops[2] - p0, 32'd8);
        chk("t2_beats", 32'(n_beats - beats0), 32'd8);
        chk("t2_lasts", 32'(n_lasts - lasts0), 32'd8);

        // Urgent channel jumps the queue.
        ptr_to_one();
        b = gq.size();
        set_limits(BIG, BIG, BIG, BIG);
        ch_almost_full = 4'b1000;
        burst_len = 8'd2;
        enable = 1'b1;
        wait_grants(b + 1, 50);
        ch_almost_full = 4'b0000;
        wait_grants(b + 2, 50);
        enable = 1'b0;
        wait_idle(50);
        chk("t3_g0", 32'(gq[b]),   32'd3);
        chk("t3_g1", 32'(gq[b+1]), 32'd0);

        // Downstream stall mid-burst.
        b = gq.size(); beats0 = n_beats; lasts0 = n_lasts; p0 = pops[1];
        set_limits(0, BIG, 0, 0);
        burst_len = 8'd8;
        enable = 1'b1;
        wait_grants(b + 1, 50);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_stall_rdy", 32'(ch_ready), 32'd0);
        out_ready = 1'b1;
        wait_idle(100);
        chk("t4_g",     32'(gq[b]), 32'd1);
        chk("t4_pops",  pops[1] - p0, 32'd8);
        chk("t4_beats", 32'(n_beats - beats0), 32'd8);
        chk("t4_lasts", 32'(n_lasts - lasts0), 32'd1);

        // Channel 1 runs dry after two beats of eight.
        ptr_to_one();
        b = gq.size(); beats0 = n_beats; lasts0 = n_lasts; p0 = pops[1];
        set_limits(0, 2, BIG, 0);
        burst_len = 8'd8;
        enable = 1'b1;
        wait_grants(b + 2, 50);
        enable = 1'b0;
        wait_idle(100);
        chk("t5_g0", 32'(gq[b]),   32'd1);
        chk("t5_g1", 32'(gq[b+1]), 32'd2);
        chk("t5_pops",  pops[1] - p0, 32'd2);
        chk("t5_beats", 32'(n_beats - beats0), 32'd10);
        chk("t5_lasts", 32'(n_lasts - lasts0), 32'd1);

        // Asynchronous reset in the middle of a burst.
        b = gq.size();
        set_limits(BIG, BIG, BIG, BIG);
        burst_len = 8'd8;
        enable = 1'b1;
        wait_grants(b + 1, 50);
        chk("t6_g_pre", 32'(gq[b]), 32'd3);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_ch_ready",  32'(ch_ready),  32'd0);
        chk("t6_busy",      32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        b = gq.size();
        wait_grants(b + 1, 50);
        enable = 1'b0;
        chk("t6_g_post", 32'(gq[b]), 32'd0);
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
